// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Each grant allows up to BURST_MAX writes; stalls on Fifo_full without releasing the grant.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          Clk,
    input  logic                          Clr,
    input  logic [NUM_REQ-1:0]            Req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_data,
    output logic [NUM_REQ-1:0]            Req_ready,
    input  logic                          Fifo_full,
    output logic                          Fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         Fifo_wr_data,
    output logic                          Grant_active,
    output logic [ID_WIDTH-1:0]           Grant_id
);

    // state | meaning
    // IDLE  | no owner; arbitrate among valid requesters this cycle
    // GRANT | owner holds the write port until burst limit or owner drops valid
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] owner, owner_nxt;
    logic [ID_WIDTH-1:0] last_grant, last_grant_nxt;
    logic [7:0]          burst_cnt, burst_cnt_nxt;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_id;
    logic                owner_valid;
    logic                transfer;

    // Search upward from last_grant+1; the index wraps naturally at ID_WIDTH bits.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && Req_valid[last_grant + ID_WIDTH'(k)]) begin
                pick_found = 1'b1;
                pick_id    = last_grant + ID_WIDTH'(k);
            end
        end
    end

    assign owner_valid = Req_valid[owner];
    assign transfer    = (state == GRANT) && owner_valid && !Fifo_full;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        Req_ready      = '0;
        Fifo_wr_en     = 1'b0;
        Fifo_wr_data   = '0;
        Grant_active   = 1'b0;
        Grant_id       = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt      = GRANT;
                    owner_nxt      = pick_id;
                    last_grant_nxt = pick_id;
                    burst_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                Grant_active     = 1'b1;
                Grant_id         = owner;
                Req_ready[owner] = !Fifo_full;
                Fifo_wr_en       = transfer;
                if (transfer) begin
                    Fifo_wr_data  = Req_data[owner*DATA_WIDTH +: DATA_WIDTH];
                    burst_cnt_nxt = burst_cnt + 8'd1;
                end
                if ((transfer && burst_cnt == BURST_LAST) || !owner_valid)
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic compared against a behavioural round-robin model.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int DW = 8;
    localparam int BM = 4;

    logic             Clk = 1'b0;
    logic             Clr;
    logic [NR-1:0]    Req_valid;
    logic [NR*DW-1:0] Req_data;
    logic [NR-1:0]    Req_ready;
    logic             Fifo_full;
    logic             Fifo_wr_en;
    logic [DW-1:0]    Fifo_wr_data;
    logic             Grant_active;
    logic [IW-1:0]    Grant_id;

    always #5 Clk = ~Clk;

    fifo_write_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IW), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .Clk(Clk), .Clr(Clr), .Req_valid(Req_valid), .Req_data(Req_data), .Req_ready(Req_ready),
        .Fifo_full(Fifo_full), .Fifo_wr_en(Fifo_wr_en), .Fifo_wr_data(Fifo_wr_data),
        .Grant_active(Grant_active), .Grant_id(Grant_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner holds port; counts writes; ptr = last granted requester.
    bit m_active;
    int m_owner, m_cnt, m_ptr;

    logic          s_active, s_wr;
    logic [IW-1:0] s_id;
    logic [NR-1:0] s_ready;
    logic [DW-1:0] s_data;

    typedef struct {
        logic [NR-1:0] v;
        logic          f;
        logic          ea;
        logic [IW-1:0] eid;
        logic [NR-1:0] erdy;
        logic          ew;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = NR - 1;
    endtask

    task automatic do_reset();
        Req_valid = '0;
        Fifo_full = 1'b0;
        Req_data  = '0;
        Clr       = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        Clr = 1'b0;
    endtask

    // Drive one cycle of inputs, sample at negedge, compare with model, advance to posedge+1.
    task automatic step(input logic [NR-1:0] v, input logic f, input logic [NR*DW-1:0] d);
        logic          e_active, e_wr;
        logic [NR-1:0] e_ready;
        logic [DW-1:0] e_data;
        int            e_id;
        Req_valid = v;
        Fifo_full = f;
        Req_data  = d;
        @(negedge Clk);
        s_active = Grant_active;
        s_id     = Grant_id;
        s_ready  = Req_ready;
        s_wr     = Fifo_wr_en;
        s_data   = Fifo_wr_data;
        e_active = 1'b0; e_wr = 1'b0; e_ready = '0; e_data = '0; e_id = 0;
        if (!m_active) begin
            for (int k = 1; k <= NR; k++) begin
                if (v[(m_ptr + k) % NR]) begin
                    m_owner  = (m_ptr + k) % NR;
                    m_ptr    = m_owner;
                    m_cnt    = 0;
                    m_active = 1'b1;
                    break;
                end
            end
        end else begin
            e_active = 1'b1;
            e_id     = m_owner;
            e_ready  = f ? '0 : NR'(1 << m_owner);
            e_wr     = v[m_owner] && !f;
            if (e_wr) begin
                e_data = d[m_owner*DW +: DW];
                m_cnt++;
            end
            if ((e_wr && m_cnt == BM) || !v[m_owner]) m_active = 1'b0;
        end
        check("model_active", 32'(s_active), 32'(e_active));
        check("model_ready", 32'(s_ready), 32'(e_ready));
        check("model_wr_en", 32'(s_wr), 32'(e_wr));
        check("model_wr_data", 32'(s_data), 32'(e_data));
        if (e_active) check("model_grant_id", 32'(s_id), 32'(e_id));
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] lane(input int idx, input logic [DW-1:0] w);
        logic [NR*DW-1:0] r;
        r = '0;
        r[idx*DW +: DW] = w;
        return r;
    endfunction

    initial begin
        logic [NR*DW-1:0] dfix;
        int writes, word_idx;
        logic [DW-1:0] word;

        dfix = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tbl[0]  = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        tbl[2]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        tbl[3]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h00};
        tbl[4]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h00};
        tbl[5]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h00};
        tbl[6]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        tbl[7]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hA1};
        tbl[8]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[9]  = '{4'b1001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0};
        tbl[10] = '{4'b1000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00};
        tbl[11] = '{4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[12] = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hA3};
        tbl[13] = '{4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[15] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        tbl[16] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h00};
        tbl[17] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h00};
        tbl[18] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

        Req_valid = '0; Fifo_full = 1'b0; Req_data = '0; Clr = 1'b1;
        model_reset();
        @(posedge Clk); #1;
        check("reset_active", 32'(Grant_active), 32'd0);
        check("reset_id", 32'(Grant_id), 32'd0);
        check("reset_ready", 32'(Req_ready), 32'd0);
        check("reset_wr_en", 32'(Fifo_wr_en), 32'd0);
        check("reset_wr_data", 32'(Fifo_wr_data), 32'd0);
        Clr = 1'b0;

        // Backpressure, early release, release while full.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].f, dfix);
            check($sformatf("tbl%0d_active", i), 32'(s_active), 32'(tbl[i].ea));
            check($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].erdy));
            check($sformatf("tbl%0d_wr_en", i), 32'(s_wr), 32'(tbl[i].ew));
            check($sformatf("tbl%0d_wr_data", i), 32'(s_data), 32'(tbl[i].ed));
            if (tbl[i].ea) check($sformatf("tbl%0d_id", i), 32'(s_id), 32'(tbl[i].eid));
        end

        // Fairness: all valid -> grants 0,1,2,3,0 with 4 writes each and one idle cycle between.
        do_reset();
        writes = 0;
        for (int c = 0; c < 25; c++) begin
            step(4'b1111, 1'b0, dfix);
            check($sformatf("fair_wr_c%0d", c), 32'(s_wr), 32'((c % 5) != 0));
            if (s_wr) begin
                check($sformatf("fair_id_w%0d", writes), 32'(s_id), 32'((writes / 4) % 4));
                writes++;
            end
        end
        check("fair_total_writes", 32'(writes), 32'd20);

        // Single requester 2 streaming 0x10..0x17.
        do_reset();
        word_idx = 0;
        for (int c = 0; c < 10; c++) begin
            word = 8'h10 + 8'(word_idx);
            step(4'b0100, 1'b0, lane(2, word));
            check($sformatf("single_wr_c%0d", c), 32'(s_wr), 32'((c % 5) != 0));
            if (s_wr) begin
                check($sformatf("single_data_w%0d", word_idx), 32'(s_data), 32'(word));
                check($sformatf("single_id_w%0d", word_idx), 32'(s_id), 32'd2);
                word_idx++;
            end
        end
        check("single_total_writes", 32'(word_idx), 32'd8);

        // Reset mid-burst: Clr after 2nd write of requester 2; outputs clear immediately.
        do_reset();
        writes = 0;
        for (int c = 0; c < 10 && writes < 2; c++) begin
            step(4'b0100, 1'b0, dfix);
            if (s_wr) writes++;
        end
        check("midrst_two_writes", 32'(writes), 32'd2);
        Req_valid = 4'b0100;
        Clr = 1'b1;
        model_reset();
        #1;
        check("midrst_active", 32'(Grant_active), 32'd0);
        check("midrst_ready", 32'(Req_ready), 32'd0);
        check("midrst_wr_en", 32'(Fifo_wr_en), 32'd0);
        check("midrst_wr_data", 32'(Fifo_wr_data), 32'd0);
        @(posedge Clk); #1;
        Clr = 1'b0;
        step(4'b0101, 1'b0, dfix);
        check("midrst_idle_after", 32'(s_active), 32'd0);
        step(4'b0101, 1'b0, dfix);
        check("midrst_regrant_active", 32'(s_active), 32'd1);
        check("midrst_regrant_id", 32'(s_id), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(NR'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 {$urandom, 32'(0)} >> 32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's 8-bit FIFO among NUM_REQ producers.
- Each producer has a valid/ready handshake. The arbiter grants one owner at a time, for a bounded burst.
- It muxes the owner's data onto the FIFO write port and stalls on the FIFO Full flag.
- Sits directly in front of the FIFO write side, in the FIFO write clock domain.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_WIDTH, 2, width of the grant index; equals log2(NUM_REQ).
- DATA_WIDTH, 8, width of one FIFO word.
- BURST_MAX, 4, maximum consecutive writes per grant before forced rotation; range 1..255.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Clr  input  1  reset, asynchronous, active-high.
- Req_valid  input  NUM_REQ  bit i = requester i has a word.
- Req_data  input  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- Req_ready  output  NUM_REQ  bit i = word from requester i accepted this cycle if valid.
- Fifo_full  input  1  FIFO cannot accept a write this cycle.
- Fifo_wr_en  output  1  write strobe to FIFO.
- Fifo_wr_data  output  DATA_WIDTH  word to FIFO.
- Grant_active  output  1  an owner holds the port.
- Grant_id  output  ID_WIDTH  current owner index; valid only when Grant_active=1.

Behaviour:
- Reset (Clr=1, any time, including mid-burst):
  - State=IDLE, Grant_active=0, Grant_id=0, burst count=0.
  - Last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
  - Req_ready=0, Fifo_wr_en=0, Fifo_wr_data=0.
  - Outputs take these values immediately, not at the next edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any Req_valid bit is set, select the first set bit searching upward from (last-grant+1) mod NUM_REQ.
  - Register the selection as owner and last-grant, clear burst count, go to GRANT.
  - No valid bits: stay in IDLE.
  - Arbitration costs one cycle; Req_ready=0 in IDLE.
- GRANT:
  - Grant_active=1, Grant_id=owner.
  - Req_ready[owner] = !Fifo_full; all other ready bits 0.
  - Transfer = Req_valid[owner] & Req_ready[owner].
  - Fifo_wr_en = transfer and Fifo_wr_data = owner's word, both combinational in the same cycle. Fifo_wr_data=0 when there is no transfer.
  - Each transfer increments burst count.
- Release from GRANT to IDLE at the clock edge when either condition holds:
  - (a) a transfer occurs with burst count == BURST_MAX-1, or
  - (b) Req_valid[owner]=0.
- Fifo_full=1 with owner valid: stall. No write, count held, grant held indefinitely; Full alone never releases.
- Owner drops valid while Full is asserted: rule (b) applies and the grant is released.
- Rotation: after release, IDLE searches from owner+1. A lone active requester is regranted after one idle cycle, giving a BURST_MAX-of-(BURST_MAX+1) cycle duty.
- Non-owner Req_valid changes never affect the current grant.
- Data is never dropped or duplicated: exactly one FIFO write per transfer.
- Arithmetic: burst count is an 8-bit unsigned register. Pointer increment wraps modulo NUM_REQ; NUM_REQ is a power of two.

Test Plan:
- Reset: assert Clr mid-simulation -> Grant_active=0, Req_ready=0000, Fifo_wr_en=0, Fifo_wr_data=0x00 immediately. Deassert, then raise all valids -> first grant is Grant_id=0.
- Single requester: requester 2 valid continuously with words 0x10..0x17, Fifo_full=0, BURST_MAX=4 -> writes 0x10,0x11,0x12,0x13, one idle cycle, regrant id 2, then writes 0x14..0x17.
- Fairness: all four requesters valid continuously -> Grant_id sequence 0,1,2,3,0. Each grant gives exactly 4 Fifo_wr_en pulses, separated by one idle cycle.
- Backpressure: requester 1 owner, raise Fifo_full after 2 writes for 3 cycles -> Req_ready=0 and Fifo_wr_en=0 for those 3 cycles, Grant_id stays 1. The remaining 2 writes follow, 4 in total, no loss.
- Early release: requester 0 drops valid after 1 write while requester 3 is valid -> IDLE for one cycle, then Grant_id=3.
- Reset mid-burst: Clr pulsed after the 2nd write of a requester 2 burst -> no further write. After reset, with requesters 0 and 2 valid, Grant_id=0 is granted first.
